// File: rtl/pid_tick_scheduler.sv
// rtl/pid_tick_scheduler.sv - periodic sample/PID-start/PWM-load sequencer with overrun and timeout flags
// Optional: define OVERRUN_COUNT_EN to add the 8-bit saturating ovr_count output.
module pid_tick_scheduler #(
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] period,
   output logic       sample,
   output logic       pid_start,
   input  logic       pid_done,
   output logic       pwm_load,
   output logic       busy,
   output logic       overrun,
   output logic       timeout_err,
`ifdef OVERRUN_COUNT_EN
   output logic [7:0] ovr_count,
`endif
   input  logic       clr_status
);

   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      SAMPLE,
      START,
      WAIT,
      LOAD
   } state_t;

   state_t        state;
   logic [7:0]    cnt;
   logic [7:0]    period_q;
   logic [7:0]    per_eff;
   logic          load_pend;
   logic          tick;
   logic          drop;
   logic          timeout_hit;
   logic [WW-1:0] wait_cnt;

   // The first interval after reset uses the live period input, since period_q is not loaded yet.
   assign per_eff     = load_pend ? period : period_q;
   assign tick        = enable && (cnt == per_eff);
   assign drop        = tick && (state != IDLE);
   assign timeout_hit = (state == WAIT) && !pid_done && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         period_q  <= '0;
         load_pend <= 1'b1;
      end else begin
         load_pend <= 1'b0;
         if (load_pend) begin
            period_q <= period;
         end
         if (!enable) begin
            cnt <= '0;
         end else if (cnt == per_eff) begin
            cnt      <= '0;
            period_q <= period;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         sample      <= 1'b0;
         pid_start   <= 1'b0;
         pwm_load    <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         sample    <= 1'b0;
         pid_start <= 1'b0;
         pwm_load  <= 1'b0;
         case (state)
            IDLE: begin
               if (tick) begin
                  state  <= SAMPLE;
                  sample <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            SAMPLE: begin
               state     <= START;
               pid_start <= 1'b1;
            end
            START: begin
               state    <= WAIT;
               wait_cnt <= '0;
            end
            WAIT: begin
               // pid_done is checked first so it wins over a coincident timeout.
               if (pid_done) begin
                  state    <= LOAD;
                  pwm_load <= 1'b1;
               end else if (wait_cnt == WAIT_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            LOAD: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         if (drop) begin
            overrun <= 1'b1;
         end else if (clr_status) begin
            overrun <= 1'b0;
         end

         if (timeout_hit) begin
            timeout_err <= 1'b1;
         end else if (clr_status) begin
            timeout_err <= 1'b0;
         end
      end
   end

`ifdef OVERRUN_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovr_count <= '0;
      end else if (drop) begin
         if (ovr_count != 8'hFF) begin
            ovr_count <= ovr_count + 8'd1;
         end
      end else if (clr_status) begin
         ovr_count <= '0;
      end
   end
`endif

endmodule
